// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD timing engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    IDLE  = 3'd5
  } lcd_state_e;

  // Power-on init: 8-bit bus/2 lines, display on, clear, entry mode increment.
  // Entry 0 sits in the lowest byte.
  localparam logic [2:0]      INIT_LEN = 3'd5;
  localparam logic [4:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38};

  // Bounds-checked ROM read; out-of-range indices return a harmless NOP-like 0.
  function automatic logic [7:0] lcd_init_byte(input logic [2:0] idx);
    logic [7:0] b;
    if (idx < INIT_LEN) begin
      b = INIT_ROM[idx];
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable 32-bit down-counter; o_zero is high while the count is zero.
module lcd_timer #(
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_val,
  output logic        o_zero
);

  logic [31:0] cnt_q, cnt_d;
  logic        zero_q, zero_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (i_load) begin
      cnt_d  = i_val;
      zero_d = (i_val == 32'd0);
    end else if (cnt_q != 32'd0) begin
      cnt_d  = cnt_q - 32'd1;
      zero_d = (cnt_q == 32'd1);
    end else begin
      cnt_d  = cnt_q;
      zero_d = 1'b1;
    end
  end

  // Counter and registered zero flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= RST_VAL;
      zero_q <= (RST_VAL == 32'd0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign o_zero = zero_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only timing engine: power-on init, then one bus write per
// software toggle of the request bit, with setup/enable/hold/exec timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter logic [31:0] T_PWRUP_CYC = 32'd2_000_000,
  parameter logic [31:0] T_SETUP_CYC = 32'd2,
  parameter logic [31:0] T_EN_CYC    = 32'd12,
  parameter logic [31:0] T_HOLD_CYC  = 32'd2,
  parameter logic [31:0] T_EXEC_CYC  = 32'd2_000,
  parameter logic [31:0] T_CLR_CYC   = 32'd82_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_overrun
);

  lcd_state_e  state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        init_done_q, init_done_d;
  logic        overrun_q, overrun_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_v_q, pend_v_d;
  logic        pend_rs_q, pend_rs_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        tog_q;

  logic        new_req_s;
  logic        pop_s;
  logic        tmr_load_s;
  logic [31:0] tmr_val_s;
  logic        tmr_zero_s;
  logic        unused_s;

  assign new_req_s = i_lcd_word[30] ^ tog_q;
  assign unused_s  = ^{i_lcd_word[29:10], i_lcd_word[8]};

  // Reset leaves the timer armed for the power-up wait, as if PWRUP was just entered.
  lcd_timer #(
    .RST_VAL (T_PWRUP_CYC - 32'd1)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (tmr_load_s),
    .i_val   (tmr_val_s),
    .o_zero  (tmr_zero_s)
  );

  // Sequencer: every state lasts until the timer reaches zero (IDLE waits for work).
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    data_d      = data_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    pop_s       = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = 32'd0;
    case (state_q)
      PWRUP: begin
        if (tmr_zero_s) begin
          state_d    = SETUP;
          rs_d       = 1'b0;
          data_d     = lcd_init_byte(3'd0);
          idx_d      = 3'd0;
          tmr_load_s = 1'b1;
          tmr_val_s  = T_SETUP_CYC - 32'd1;
        end else begin
          state_d = PWRUP;
        end
      end
      SETUP: begin
        if (tmr_zero_s) begin
          state_d    = EN_HI;
          tmr_load_s = 1'b1;
          tmr_val_s  = T_EN_CYC - 32'd1;
        end else begin
          state_d = SETUP;
        end
      end
      EN_HI: begin
        if (tmr_zero_s) begin
          state_d    = HOLD;
          tmr_load_s = 1'b1;
          tmr_val_s  = T_HOLD_CYC - 32'd1;
        end else begin
          state_d = EN_HI;
        end
      end
      HOLD: begin
        if (tmr_zero_s) begin
          state_d    = EXEC;
          tmr_load_s = 1'b1;
          if (lcd_is_long_cmd(rs_q, data_q)) begin
            tmr_val_s = T_CLR_CYC - 32'd1;
          end else begin
            tmr_val_s = T_EXEC_CYC - 32'd1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      EXEC: begin
        if (!tmr_zero_s) begin
          state_d = EXEC;
        end else if (!init_done_q && (idx_q != (INIT_LEN - 3'd1))) begin
          state_d    = SETUP;
          idx_d      = idx_q + 3'd1;
          rs_d       = 1'b0;
          data_d     = lcd_init_byte(idx_q + 3'd1);
          tmr_load_s = 1'b1;
          tmr_val_s  = T_SETUP_CYC - 32'd1;
        end else begin
          // Last init entry (or any user byte) finished; the flag is sticky.
          init_done_d = 1'b1;
          if (pend_v_q) begin
            state_d    = SETUP;
            rs_d       = pend_rs_q;
            data_d     = pend_data_q;
            pop_s      = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = T_SETUP_CYC - 32'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (pend_v_q) begin
          state_d    = SETUP;
          rs_d       = pend_rs_q;
          data_d     = pend_data_q;
          pop_s      = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = T_SETUP_CYC - 32'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = PWRUP;
        tmr_load_s = 1'b1;
        tmr_val_s  = T_PWRUP_CYC - 32'd1;
      end
    endcase
  end

  // One-deep request buffer; a request landing on a pop cycle is not an overrun.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    overrun_d   = overrun_q;
    if (new_req_s) begin
      pend_v_d    = 1'b1;
      pend_rs_d   = i_lcd_word[9];
      pend_data_d = i_lcd_word[7:0];
      if (pend_v_q && !pop_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (pop_s) begin
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // EN follows the next state so it is high exactly while in EN_HI; busy lags state by one.
  always_comb begin
    en_d   = (state_d == EN_HI);
    busy_d = (state_q != IDLE);
  end

  // State and output registers; the toggle shadow tracks bit 30 even in reset.
  always_ff @(posedge i_clk) begin
    tog_q <= i_lcd_word[30];
    if (i_reset) begin
      state_q     <= PWRUP;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      idx_q       <= 3'd0;
      pend_v_q    <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      overrun_q   <= overrun_d;
      idx_q       <= idx_d;
      pend_v_q    <= pend_v_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = i_lcd_word[31];
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_overrun   = overrun_q;

endmodule
